// File: rtl/memwb_debug_reader_if.sv
// Byte stream from the MEM/WB debug reader to the debug UART transmitter.
// A byte moves on a rising edge where tx_valid and tx_ready are both high.
interface memwb_debug_reader_if;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;

    modport master (output tx_valid, output tx_data, input tx_ready);
    modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/memwb_debug_reader.sv
// Snapshots the MEM/WB latch on a dump request and streams it as a 12-byte frame:
// header, rd_data, addr_mem, addr_dest, {WB, opcode}, XOR checksum of bytes 1..10.
//
// state | meaning
// IDLE  | waiting for dump_req; done may pulse here for one cycle after a frame
// SEND  | frame in progress; tx_data holds byte idx until the transmitter accepts it
module memwb_debug_reader #(
    parameter int         msb    = 31,
    parameter logic [7:0] HEADER = 8'hA5
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       dump_req,
    input  logic [msb:0]               in_rd_data,
    input  logic [msb:0]               in_addr_mem,
    input  logic [4:0]                 in_addr_dest,
    input  logic [1:0]                 in_WB,
    input  logic [5:0]                 in_opcodeWB,
    memwb_debug_reader_if.master       tx,
    output logic                       busy,
    output logic                       done
);

    typedef enum logic {IDLE, SEND} state_t;

    state_t       state;
    logic [3:0]   idx;
    logic [msb:0] snap_rd;
    logic [msb:0] snap_addr;
    logic [4:0]   snap_dest;
    logic [1:0]   snap_wb;
    logic [5:0]   snap_op;
    logic         valid_q;
    logic [7:0]   data_q;

    logic [3:0]   next_idx;
    logic [7:0]   next_byte;
    logic [7:0]   checksum;

    assign tx.tx_valid = valid_q;
    assign tx.tx_data  = data_q;

    // The snapshot is frozen during SEND, so the checksum can be formed directly from it.
    always_comb begin
        next_idx  = idx + 4'd1;
        checksum  = snap_rd[31:24] ^ snap_rd[23:16] ^ snap_rd[15:8] ^ snap_rd[7:0]
                  ^ snap_addr[31:24] ^ snap_addr[23:16] ^ snap_addr[15:8] ^ snap_addr[7:0]
                  ^ {3'b000, snap_dest} ^ {snap_wb, snap_op};
        next_byte = 8'h00;
        case (next_idx)
            4'd1:    next_byte = snap_rd[31:24];
            4'd2:    next_byte = snap_rd[23:16];
            4'd3:    next_byte = snap_rd[15:8];
            4'd4:    next_byte = snap_rd[7:0];
            4'd5:    next_byte = snap_addr[31:24];
            4'd6:    next_byte = snap_addr[23:16];
            4'd7:    next_byte = snap_addr[15:8];
            4'd8:    next_byte = snap_addr[7:0];
            4'd9:    next_byte = {3'b000, snap_dest};
            4'd10:   next_byte = {snap_wb, snap_op};
            4'd11:   next_byte = checksum;
            default: next_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= 4'd0;
            snap_rd   <= '0;
            snap_addr <= '0;
            snap_dest <= 5'd0;
            snap_wb   <= 2'd0;
            snap_op   <= 6'd0;
            valid_q   <= 1'b0;
            data_q    <= 8'h00;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (dump_req) begin
                        snap_rd   <= in_rd_data;
                        snap_addr <= in_addr_mem;
                        snap_dest <= in_addr_dest;
                        snap_wb   <= in_WB;
                        snap_op   <= in_opcodeWB;
                        idx       <= 4'd0;
                        valid_q   <= 1'b1;
                        data_q    <= HEADER;
                        busy      <= 1'b1;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    // dump_req is deliberately not looked at here, even on the last byte.
                    if (valid_q && tx.tx_ready) begin
                        if (idx == 4'd11) begin
                            idx     <= 4'd0;
                            valid_q <= 1'b0;
                            data_q  <= 8'h00;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            idx    <= next_idx;
                            data_q <= next_byte;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memwb_debug_reader.sv
// Bench for memwb_debug_reader: expected frame bytes are queued when a dump is requested
// and popped as the transmitter side accepts bytes.
module tb_memwb_debug_reader;

    logic        clk;
    logic        reset;
    logic        dump_req;
    logic [31:0] in_rd_data;
    logic [31:0] in_addr_mem;
    logic [4:0]  in_addr_dest;
    logic [1:0]  in_WB;
    logic [5:0]  in_opcodeWB;
    logic        tx_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        busy;
    logic        done;

    memwb_debug_reader_if tx_bus();
    assign tx_bus.tx_ready = tx_ready;
    assign tx_valid        = tx_bus.tx_valid;
    assign tx_data         = tx_bus.tx_data;

    memwb_debug_reader dut (
        .clk         (clk),
        .reset       (reset),
        .dump_req    (dump_req),
        .in_rd_data  (in_rd_data),
        .in_addr_mem (in_addr_mem),
        .in_addr_dest(in_addr_dest),
        .in_WB       (in_WB),
        .in_opcodeWB (in_opcodeWB),
        .tx          (tx_bus),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         tests = 0;
    int         fails = 0;
    logic [7:0] exp_q[$];

    // Monitor: inputs change just after rising edges, so negedge values are what the next edge sees.
    int         frame_pos  = 0;
    logic       pend_done  = 1'b0;
    logic       stall_prev = 1'b0;
    logic [7:0] stall_data = 8'h00;
    logic [7:0] exp_b;

    always @(negedge clk) begin
        if (reset) begin
            frame_pos  = 0;
            pend_done  = 1'b0;
            stall_prev = 1'b0;
        end else begin
            tests++;
            assert (done === pend_done) else begin
                fails++;
                $error("FAIL done_pulse observed=%b expected=%b", done, pend_done);
            end
            if (stall_prev) begin
                tests++;
                assert (tx_valid === 1'b1 && tx_data === stall_data) else begin
                    fails++;
                    $error("FAIL stall_hold observed=%b/%h expected=1/%h", tx_valid, tx_data, stall_data);
                end
            end
            pend_done = 1'b0;
            if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
                tests++;
                assert (exp_q.size() > 0) else begin
                    fails++;
                    $error("FAIL unexpected_byte observed=%h expected=none", tx_data);
                end
                if (exp_q.size() > 0) begin
                    exp_b = exp_q.pop_front();
                    tests++;
                    assert (tx_data === exp_b) else begin
                        fails++;
                        $error("FAIL frame_byte pos=%0d observed=%h expected=%h", frame_pos, tx_data, exp_b);
                    end
                end
                frame_pos++;
                if (frame_pos == 12) begin
                    frame_pos = 0;
                    pend_done = 1'b1;
                end
            end
            stall_prev = (tx_valid === 1'b1 && tx_ready !== 1'b1);
            stall_data = tx_data;
        end
    end

    task automatic check1(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_inputs(input logic [31:0] rd, input logic [31:0] am, input logic [4:0] ad,
                              input logic [1:0] wb, input logic [5:0] op);
        in_rd_data   = rd;
        in_addr_mem  = am;
        in_addr_dest = ad;
        in_WB        = wb;
        in_opcodeWB  = op;
    endtask

    task automatic push_frame(input logic [31:0] rd, input logic [31:0] am, input logic [4:0] ad,
                              input logic [1:0] wb, input logic [5:0] op);
        logic [7:0] b[12];
        logic [7:0] x;
        b[0]  = 8'hA5;
        b[1]  = rd[31:24]; b[2] = rd[23:16]; b[3] = rd[15:8]; b[4] = rd[7:0];
        b[5]  = am[31:24]; b[6] = am[23:16]; b[7] = am[15:8]; b[8] = am[7:0];
        b[9]  = {3'b000, ad};
        b[10] = {wb, op};
        x = 8'h00;
        for (int i = 1; i <= 10; i++) x = x ^ b[i];
        b[11] = x;
        for (int i = 0; i < 12; i++) exp_q.push_back(b[i]);
    endtask

    // Reference frame for the basic pattern, written out by hand.
    task automatic push_basic();
        logic [7:0] k[12];
        k = '{8'hA5, 8'h12, 8'h34, 8'h56, 8'h78, 8'h00, 8'h00, 8'h00, 8'h10, 8'h09, 8'hE3, 8'hF2};
        for (int i = 0; i < 12; i++) exp_q.push_back(k[i]);
    endtask

    task automatic set_basic();
        set_inputs(32'h12345678, 32'h00000010, 5'd9, 2'b11, 6'h23);
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        tests++;
        assert (exp_q.size() == 0) else begin
            fails++;
            $error("FAIL %s_timeout observed=%0d_left expected=0_left", tag, exp_q.size());
        end
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        reset    = 1'b1;
        dump_req = 1'b0;
        tx_ready = 1'b0;
        set_inputs(32'h0, 32'h0, 5'd0, 2'd0, 6'd0);
        repeat (3) @(posedge clk);
        #1;
        check1("reset_tx_valid", {7'd0, tx_valid}, 8'h00);
        check1("reset_tx_data", tx_data, 8'h00);
        check1("reset_busy", {7'd0, busy}, 8'h00);
        check1("reset_done", {7'd0, done}, 8'h00);
        reset = 1'b0;

        // Basic frame, tx_ready high, with latency checks
        @(posedge clk); #1;
        set_basic();
        tx_ready = 1'b1;
        dump_req = 1'b1;
        push_basic();
        @(posedge clk); #1;
        dump_req = 1'b0;
        check1("first_busy", {7'd0, busy}, 8'h01);
        check1("first_valid", {7'd0, tx_valid}, 8'h01);
        check1("first_header", tx_data, 8'hA5);
        repeat (11) @(posedge clk);
        #1;
        check1("done_not_early", {7'd0, done}, 8'h00);
        @(posedge clk); #1;
        check1("done_at_12", {7'd0, done}, 8'h01);
        check1("end_valid", {7'd0, tx_valid}, 8'h00);
        check1("end_busy", {7'd0, busy}, 8'h00);
        wait_drain("basic", 5);

        // Backpressure with random ready and two 5-cycle low stretches
        tx_ready = 1'b0;
        dump_req = 1'b1;
        push_basic();
        @(posedge clk); #1;
        dump_req = 1'b0;
        for (int c = 0; c < 400 && exp_q.size() != 0; c++) begin
            if ((c >= 2 && c < 7) || (c >= 15 && c < 20)) tx_ready = 1'b0;
            else tx_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        tx_ready = 1'b1;
        wait_drain("backpressure", 30);

        // Snapshot freeze: inputs jump to all-ones right after the request edge
        dump_req = 1'b1;
        push_basic();
        @(posedge clk); #1;
        dump_req = 1'b0;
        set_inputs(32'hFFFFFFFF, 32'hFFFFFFFF, 5'h1F, 2'b11, 6'h3F);
        wait_drain("freeze", 30);

        // dump_req held through a whole frame: second frame starts on the done cycle
        set_basic();
        dump_req = 1'b1;
        push_basic();
        @(posedge clk); #1;
        set_inputs(32'hCAFEF00D, 32'h8000_0004, 5'd31, 2'b01, 6'h2B);
        push_frame(32'hCAFEF00D, 32'h8000_0004, 5'd31, 2'b01, 6'h2B);
        repeat (13) @(posedge clk);
        #1;
        dump_req = 1'b0;
        wait_drain("held_req", 40);
        repeat (5) @(posedge clk);
        #1;

        // Single pulse while byte 6 is being accepted is ignored
        set_inputs(32'hDEADBEEF, 32'h0000_1234, 5'd3, 2'b10, 6'h05);
        dump_req = 1'b1;
        push_frame(32'hDEADBEEF, 32'h0000_1234, 5'd3, 2'b10, 6'h05);
        @(posedge clk); #1;
        dump_req = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        dump_req = 1'b1;
        @(posedge clk); #1;
        dump_req = 1'b0;
        wait_drain("pulse_ignored", 30);
        repeat (20) @(posedge clk);
        #1;
        check1("no_second_frame", {7'd0, tx_valid}, 8'h00);

        // Reset after byte 4 is accepted abandons the frame
        set_basic();
        dump_req = 1'b1;
        push_basic();
        @(posedge clk); #1;
        dump_req = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        reset = 1'b1;
        exp_q.delete();
        #1;
        check1("midreset_valid", {7'd0, tx_valid}, 8'h00);
        check1("midreset_data", tx_data, 8'h00);
        check1("midreset_busy", {7'd0, busy}, 8'h00);
        check1("midreset_done", {7'd0, done}, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        check1("held_reset_valid", {7'd0, tx_valid}, 8'h00);
        check1("held_reset_busy", {7'd0, busy}, 8'h00);
        reset = 1'b0;
        @(posedge clk); #1;
        check1("post_reset_done", {7'd0, done}, 8'h00);
        dump_req = 1'b1;
        push_basic();
        @(posedge clk); #1;
        dump_req = 1'b0;
        check1("restart_header", tx_data, 8'hA5);
        wait_drain("after_reset", 30);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
